// File: rtl/pwm_cap_pkg.sv
// pwm_cap_pkg -- shared definitions for the PWM capture block.
//   PWM_CAP_W_DEFAULT : default counter/result width in bits
//   pwm_state_e       : capture state (IDLE, HIGH, LOW)
package pwm_cap_pkg;

    localparam int unsigned PWM_CAP_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_state_e;

endpackage : pwm_cap_pkg

// File: rtl/pwm_capture_sync_edge.sv
// sync_edge -- brings an asynchronous level into the clk domain and
// detects its edges.
//   clk   : sampling clock
//   reset : asynchronous, active-high; clears all flops to 0
//   din   : asynchronous input level
//   level : synchronized level (second synchronizer stage)
//   rise  : one-cycle strobe, synchronized level went 0 -> 1
//   fall  : one-cycle strobe, synchronized level went 1 -> 0
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1_r;
    logic s2_r;
    logic s3_r;

    // Two-stage synchronizer followed by a delay stage for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= din;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign level = s2_r;
    assign rise  = s2_r & ~s3_r;
    assign fall  = ~s2_r & s3_r;

endmodule : sync_edge

// File: rtl/pwm_capture.sv
// pwm_capture -- measures period and high time of an external PWM signal.
//   clk    : clock, all state updates on its rising edge
//   reset  : asynchronous, active-high reset
//   pwm_in : PWM waveform, asynchronous to clk
//   en     : capture enable; low forces IDLE and clears the counter
//   tmo    : timeout limit in clk cycles (0 = no timeout)
//   period : last measured period (rise to rise), clk cycles, saturating
//   high   : last measured high time, clk cycles
//   valid  : one-cycle pulse when period/high update
//   stuck  : one-cycle pulse when activity is lost (timeout)
//   level  : synchronized pwm_in level latched at the last timeout
module pwm_capture
    import pwm_cap_pkg::*;
#(
    parameter int unsigned W = PWM_CAP_W_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pwm_in,
    input  logic         en,
    input  logic [W-1:0] tmo,
    output logic [W-1:0] period,
    output logic [W-1:0] high,
    output logic         valid,
    output logic         stuck,
    output logic         level
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};

    logic         sync_level_s;
    logic         rise_s;
    logic         fall_s;
    logic         timeout_s;

    pwm_state_e   state_r;
    pwm_state_e   state_nxt_s;
    logic [W-1:0] cnt_r;
    logic [W-1:0] cnt_nxt_s;
    logic [W-1:0] hi_acc_r;
    logic [W-1:0] hi_acc_nxt_s;
    logic [W-1:0] period_r;
    logic [W-1:0] period_nxt_s;
    logic [W-1:0] high_r;
    logic [W-1:0] high_nxt_s;
    logic         valid_r;
    logic         valid_nxt_s;
    logic         stuck_r;
    logic         stuck_nxt_s;
    logic         level_r;
    logic         level_nxt_s;

    sync_edge u_sync_edge (
        .clk   (clk),
        .reset (reset),
        .din   (pwm_in),
        .level (sync_level_s),
        .rise  (rise_s),
        .fall  (fall_s)
    );

    // A rise always beats a coincident timeout, so timeout excludes rise.
    assign timeout_s = (tmo != CNT_ZERO) && (cnt_r >= tmo) && !rise_s;

    // Next-state, counter and result update logic.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        hi_acc_nxt_s = hi_acc_r;
        period_nxt_s = period_r;
        high_nxt_s   = high_r;
        level_nxt_s  = level_r;
        valid_nxt_s  = 1'b0;
        stuck_nxt_s  = 1'b0;

        if (!en) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = CNT_ZERO;
        end else begin
            // Counter restarts at 1 on a rise so that the value seen on the
            // closing edge equals the number of elapsed cycles.
            if (rise_s) begin
                cnt_nxt_s = CNT_ONE;
            end else if (state_r == IDLE) begin
                cnt_nxt_s = CNT_ZERO;
            end else if (cnt_r != CNT_MAX) begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end else begin
                cnt_nxt_s = cnt_r;
            end

            case (state_r)
                IDLE: begin
                    if (rise_s) begin
                        state_nxt_s = HIGH;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                HIGH: begin
                    if (timeout_s) begin
                        state_nxt_s = IDLE;
                        cnt_nxt_s   = CNT_ZERO;
                        stuck_nxt_s = 1'b1;
                        level_nxt_s = sync_level_s;
                    end else if (fall_s) begin
                        state_nxt_s  = LOW;
                        hi_acc_nxt_s = cnt_r;
                    end else begin
                        state_nxt_s = HIGH;
                    end
                end
                LOW: begin
                    if (rise_s) begin
                        state_nxt_s  = HIGH;
                        period_nxt_s = cnt_r;
                        high_nxt_s   = hi_acc_r;
                        valid_nxt_s  = 1'b1;
                    end else if (timeout_s) begin
                        state_nxt_s = IDLE;
                        cnt_nxt_s   = CNT_ZERO;
                        stuck_nxt_s = 1'b1;
                        level_nxt_s = sync_level_s;
                    end else begin
                        state_nxt_s = LOW;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            cnt_r    <= CNT_ZERO;
            hi_acc_r <= CNT_ZERO;
            period_r <= CNT_ZERO;
            high_r   <= CNT_ZERO;
            valid_r  <= 1'b0;
            stuck_r  <= 1'b0;
            level_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            hi_acc_r <= hi_acc_nxt_s;
            period_r <= period_nxt_s;
            high_r   <= high_nxt_s;
            valid_r  <= valid_nxt_s;
            stuck_r  <= stuck_nxt_s;
            level_r  <= level_nxt_s;
        end
    end

    assign period = period_r;
    assign high   = high_r;
    assign valid  = valid_r;
    assign stuck  = stuck_r;
    assign level  = level_r;

endmodule : pwm_capture

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture -- directed self-checking bench for pwm_capture.
// Drives one pwm_in stream into a W=32 and a W=4 instance.
module tb_pwm_capture;

    logic        clk;
    logic        reset;
    logic        pwm_in;
    logic        en;
    logic [31:0] tmo;
    logic [31:0] period;
    logic [31:0] high;
    logic        valid;
    logic        stuck;
    logic        level;
    logic [3:0]  tmo4;
    logic [3:0]  period4;
    logic [3:0]  high4;
    logic        valid4;
    logic        stuck4;
    logic        level4;

    int total = 0;
    int bad   = 0;

    int vcnt    = 0;
    int scnt    = 0;
    int v4cnt   = 0;
    int pm_bad  = 0;
    bit chk_steady = 1'b0;

    int v0;
    int s0;
    int v40;

    pwm_capture #(.W(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .pwm_in (pwm_in),
        .en     (en),
        .tmo    (tmo),
        .period (period),
        .high   (high),
        .valid  (valid),
        .stuck  (stuck),
        .level  (level)
    );

    pwm_capture #(.W(4)) dut4 (
        .clk    (clk),
        .reset  (reset),
        .pwm_in (pwm_in),
        .en     (en),
        .tmo    (tmo4),
        .period (period4),
        .high   (high4),
        .valid  (valid4),
        .stuck  (stuck4),
        .level  (level4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event recorder, sampled on the falling edge.
    always @(negedge clk) begin
        if (valid) begin
            vcnt = vcnt + 1;
            if (chk_steady && ((period != 32'd10) || (high != 32'd3))) begin
                pm_bad = pm_bad + 1;
            end
        end
        if (stuck) begin
            scnt = scnt + 1;
        end
        if (valid4) begin
            v4cnt = v4cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Hold pwm_in at lv for n clock edges; called just after a rising edge.
    task automatic drive(input logic lv, input int n);
        pwm_in = lv;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        en     = 1'b0;
        pwm_in = 1'b0;
        tmo    = 32'd0;
        tmo4   = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_period", {32'd0, period}, 64'd0);
        chk("rst_high",   {32'd0, high},   64'd0);
        chk("rst_valid",  {63'd0, valid},  64'd0);
        chk("rst_stuck",  {63'd0, stuck},  64'd0);
        chk("rst_level",  {63'd0, level},  64'd0);
        reset = 1'b0;
        en    = 1'b1;

        // H=3, L=7 steady stream
        drive(1'b0, 5);
        chk_steady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 3);
            drive(1'b0, 7);
            if (i == 0) chk("first_no_valid", vcnt, 64'd0);
            if (i == 1) chk("second_rise_valid", vcnt, 64'd1);
        end
        drive(1'b1, 3);
        tmo = 32'd50;
        pwm_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk_steady = 1'b0;
        chk("steady_vcnt",   vcnt,   64'd6);
        chk("steady_values", pm_bad, 64'd0);
        chk("steady_period", {32'd0, period}, 64'd10);
        chk("steady_high",   {32'd0, high},   64'd3);

        // stuck low
        drive(1'b0, 130);
        chk("low_stuck_once", scnt, 64'd1);
        chk("low_level",  {63'd0, level}, 64'd0);
        chk("low_period", {32'd0, period}, 64'd10);
        chk("low_high",   {32'd0, high},   64'd3);
        chk("low_no_valid", vcnt, 64'd6);

        // stuck high (100% duty)
        v0 = vcnt;
        s0 = scnt;
        drive(1'b1, 80);
        chk("high_stuck",    scnt - s0, 64'd1);
        chk("high_level",    {63'd0, level}, 64'd1);
        chk("high_no_valid", vcnt - v0, 64'd0);

        // enable gap mid-HIGH, then H=4, L=4
        tmo = 32'd0;
        drive(1'b0, 10);
        v0 = vcnt;
        drive(1'b1, 4);
        en = 1'b0;
        drive(1'b1, 5);
        en = 1'b1;
        drive(1'b0, 4);
        chk("gap_no_valid", vcnt - v0, 64'd0);
        chk("gap_hold_period", {32'd0, period}, 64'd10);
        chk("gap_hold_high",   {32'd0, high},   64'd3);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4);
            drive(1'b0, 4);
            if (i == 0) chk("gap_restart_no_valid", vcnt - v0, 64'd0);
        end
        drive(1'b1, 1);
        drive(1'b0, 8);
        chk("gap_vcnt",   vcnt - v0, 64'd4);
        chk("gap_period", {32'd0, period}, 64'd8);
        chk("gap_high",   {32'd0, high},   64'd4);

        // reset mid-LOW
        drive(1'b1, 4);
        drive(1'b0, 2);
        reset = 1'b1;
        #2;
        chk("mid_rst_period", {32'd0, period}, 64'd0);
        chk("mid_rst_high",   {32'd0, high},   64'd0);
        chk("mid_rst_level",  {63'd0, level},  64'd0);
        chk("mid_rst_valid",  {63'd0, valid},  64'd0);
        v0 = vcnt;
        s0 = scnt;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b0, 2);
        drive(1'b1, 4);
        drive(1'b0, 4);
        chk("post_rst_no_valid", vcnt - v0, 64'd0);
        drive(1'b1, 4);
        drive(1'b0, 4);
        chk("post_rst_valid",  vcnt - v0, 64'd1);
        chk("post_rst_period", {32'd0, period}, 64'd8);
        chk("post_rst_high",   {32'd0, high},   64'd4);
        chk("post_rst_no_stuck", scnt - s0, 64'd0);

        // W=4 saturation with H=10, L=10
        v40 = v4cnt;
        drive(1'b0, 12);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 10);
            drive(1'b0, 10);
        end
        drive(1'b1, 1);
        drive(1'b0, 8);
        chk("sat_vcnt",   v4cnt - v40, 64'd3);
        chk("sat_period", {60'd0, period4}, 64'd15);
        chk("sat_high",   {60'd0, high4},   64'd10);
        chk("wide_period", {32'd0, period}, 64'd20);
        chk("wide_high",   {32'd0, high},   64'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pwm_capture
